// File: rtl/enc_frame_pkg.sv
// enc_frame_pkg
//  Shared definitions for the encoder frame scheduler:
//   - frame_state_t : frame sequencer states (IDLE, HDR, SEQ, DATA, CSUM)
//   - DEFAULT_SYNC_BYTE : frame header byte
//   - FRAME_LEN_* : bytes per frame for a 12-channel bank, with and without
//     the sequence byte; FRAME_LEN follows the active build.
//  Configuration macro: ENC_FRAME_SEQ_EN (adds the per-frame sequence byte).
package enc_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } frame_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // SYNC + 12 data bytes + checksum, optionally + sequence byte.
  localparam int FRAME_LEN_BASE = 14;
  localparam int FRAME_LEN_SEQ  = 15;

`ifdef ENC_FRAME_SEQ_EN
  localparam int FRAME_LEN = FRAME_LEN_SEQ;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

endpackage

// File: rtl/enc_sample_tick.sv
// enc_sample_tick
//  Free-running sample divider. Counts 0..SAMPLE_DIV-1 while en is high and
//  asserts tick for the single cycle in which the count sits at SAMPLE_DIV-1;
//  the count then wraps to 0. While en is low the count is held at 0, so the
//  first tick after enabling arrives SAMPLE_DIV cycles later.
//  Ports:
//   CLK  in  system clock
//   RST  in  synchronous reset, active-high (count -> 0)
//   en   in  sampling enable
//   tick out 1-cycle sample strobe
module enc_sample_tick #(
  parameter int SAMPLE_DIV = 16000
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST_COUNT = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_reg <= '0;
    end else if (!en) begin
      div_reg <= '0;
    end else if (div_reg == LAST_COUNT) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  // Gated by en so that dropping en in the terminal-count cycle suppresses
  // the tick as well as the count.
  assign tick = en && (div_reg == LAST_COUNT);

endmodule

// File: rtl/encoder_frame_scheduler.sv
// encoder_frame_scheduler
//  Periodically snapshots the encoder counter bank and streams it to the
//  host-link serializer as a byte frame:
//    SYNC, [SEQ], enc0 .. enc(NUM_ENC-1), CHECKSUM
//  The checksum is the mod-256 sum of every byte after SYNC (sequence byte
//  included when present). A tick that arrives while a frame is in flight is
//  dropped and latches the sticky overrun flag.
//  Configuration macro: ENC_FRAME_SEQ_EN -- inserts an 8-bit frame sequence
//  byte after SYNC (starts at 0 after reset, +1 per started frame).
//  Ports:
//   CLK          in   system clock
//   RST          in   synchronous reset, active-high; aborts any frame
//   en           in   sampling enable (an in-flight frame always completes)
//   cnt_flat     in   NUM_ENC*CNT_W counters, encoder k at [k*CNT_W +: CNT_W]
//   tx_data      out  frame byte
//   tx_valid     out  tx_data valid
//   tx_ready     in   downstream accepts byte (transfer = valid & ready)
//   frame_start  out  1-cycle pulse in the snapshot cycle
//   overrun      out  sticky: a tick was dropped
module encoder_frame_scheduler
  import enc_frame_pkg::*;
#(
  parameter int         NUM_ENC    = 12,
  parameter int         CNT_W      = 5,
  parameter int         SAMPLE_DIV = 16000,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic [NUM_ENC*CNT_W-1:0] cnt_flat,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     frame_start,
  output logic                     overrun
);

  localparam int IDX_W = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENC - 1);

  logic                 tick;
  logic                 capture;
  logic                 xfer;
  frame_state_t         state_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [IDX_W-1:0]     idx_next;
  logic [7:0]           csum_reg;
  logic [CNT_W-1:0]     cnt_arr    [NUM_ENC];
  logic [CNT_W-1:0]     shadow_reg [NUM_ENC];
`ifdef ENC_FRAME_SEQ_EN
  logic [7:0]           seq_reg;
`endif

  enc_sample_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .en  (en),
    .tick(tick)
  );

  // Split the flat counter bus into per-channel lanes.
  generate
    for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_chan
      assign cnt_arr[gi] = cnt_flat[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // A tick is only honoured in IDLE; everywhere else it is an overrun.
  assign capture     = tick && (state_reg == IDLE);
  assign frame_start = capture;
  assign xfer        = tx_valid && tx_ready;
  assign idx_next    = idx_reg + IDX_W'(1);

  // Shadow bank: loaded atomically in the snapshot cycle so the frame in
  // flight never sees live counter movement.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NUM_ENC; k++) begin
        shadow_reg[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NUM_ENC; k++) begin
        shadow_reg[k] <= cnt_arr[k];
      end
    end
  end

  // Frame sequencer. tx_data/tx_valid are registered; the next byte is
  // loaded on the same edge that completes the current transfer, so with
  // tx_ready held high one byte leaves per cycle. csum_reg accumulates each
  // post-SYNC byte as it transfers; the last data byte is folded in directly
  // when the checksum byte is loaded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      csum_reg  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      overrun   <= 1'b0;
`ifdef ENC_FRAME_SEQ_EN
      seq_reg   <= '0;
`endif
    end else begin
      if (tick && (state_reg != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_reg <= HDR;
            tx_valid  <= 1'b1;
            tx_data   <= SYNC_BYTE;
            csum_reg  <= '0;
            idx_reg   <= '0;
          end
        end

        HDR: begin
          if (xfer) begin
            idx_reg <= '0;
`ifdef ENC_FRAME_SEQ_EN
            state_reg <= SEQ;
            tx_data   <= seq_reg;
`else
            state_reg <= DATA;
            tx_data   <= 8'(shadow_reg[0]);
`endif
          end
        end

`ifdef ENC_FRAME_SEQ_EN
        SEQ: begin
          if (xfer) begin
            seq_reg   <= seq_reg + 8'd1;
            csum_reg  <= csum_reg + tx_data;
            state_reg <= DATA;
            tx_data   <= 8'(shadow_reg[0]);
          end
        end
`endif

        DATA: begin
          if (xfer) begin
            csum_reg <= csum_reg + tx_data;
            if (idx_reg == LAST_IDX) begin
              state_reg <= CSUM;
              tx_data   <= csum_reg + tx_data;
            end else begin
              idx_reg <= idx_next;
              tx_data <= 8'(shadow_reg[idx_next]);
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            state_reg <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_valid  <= 1'b0;
          tx_data   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_frame_scheduler.sv
// tb_encoder_frame_scheduler
//  Scoreboard bench: the stimulus process pushes each expected frame (with a
//  hand-computed checksum) into exp_q before the frame is sampled; a monitor
//  pops and compares every transferred byte and checks that a stalled byte
//  holds. Build with ENC_FRAME_SEQ_EN defined to exercise the sequence byte.
module tb_encoder_frame_scheduler;

  localparam int NUM_ENC = 12;
  localparam int CNT_W   = 5;
  localparam int SD      = 100;
`ifdef ENC_FRAME_SEQ_EN
  localparam int FLEN    = 15;
`else
  localparam int FLEN    = 14;
`endif

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic                     en = 1'b0;
  logic                     tx_ready = 1'b0;
  logic [NUM_ENC*CNT_W-1:0] cnt_flat = '0;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     frame_start;
  logic                     overrun;

  encoder_frame_scheduler #(
    .NUM_ENC   (NUM_ENC),
    .CNT_W     (CNT_W),
    .SAMPLE_DIV(SD),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .cnt_flat   (cnt_flat),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_start(frame_start),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         fs_count = 0;
  bit         rand_ready = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq = 8'd0;
  logic [CNT_W-1:0] vals [NUM_ENC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic set_cnt();
    for (int k = 0; k < NUM_ENC; k++) cnt_flat[k*CNT_W +: CNT_W] = vals[k];
  endtask

  // csum is the hand-computed sum of the twelve data bytes; the sequence
  // byte, when built in, is added on top.
  task automatic push_frame(input logic [7:0] csum);
    logic [7:0] c;
    c = csum;
    exp_q.push_back(8'hA5);
`ifdef ENC_FRAME_SEQ_EN
    exp_q.push_back(exp_seq);
    c = c + exp_seq;
    exp_seq = exp_seq + 8'd1;
`endif
    for (int k = 0; k < NUM_ENC; k++) exp_q.push_back(8'(vals[k]));
    exp_q.push_back(c);
  endtask

  task automatic wait_fs(input string name, input int bound, output int cyc);
    cyc = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLK);
      if (frame_start === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++;
      $display("FAIL %s: frame_start not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && tx_valid === 1'b0) break;
    end
    chk({name, "_left"}, exp_q.size(), 0);
  endtask

  // Monitor: one line per transferred byte.
  initial begin
    bit         stall_prev;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall_prev = 1'b0;
    stall_data = 8'd0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_data});
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got 0x%0h, required none", tx_data);
          end else begin
            e = exp_q.pop_front();
            $display("byte 0x%02h expected 0x%02h", tx_data, e);
            chk("frame_byte", tx_data, e);
          end
          stall_prev = 1'b0;
        end else if (tx_valid) begin
          stall_prev = 1'b1;
          stall_data = tx_data;
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (frame_start === 1'b1) fs_count++;
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nvalid;
    int fs0;

    // Reset and idle with sampling disabled.
    RST = 1'b1; en = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    fs0 = fs_count;
    nvalid = 0;
    repeat (20000) begin
      @(negedge CLK);
      if (tx_valid !== 1'b0) nvalid++;
    end
    chk("idle_frame_starts", fs_count - fs0, 0);
    chk("idle_valid_cycles", nvalid, 0);
    chk("idle_overrun", overrun, 0);

    // Basic frame: channel k = k.
    @(posedge CLK); #1;
    RST = 1'b1; en = 1'b1; tx_ready = 1'b1;
    for (int k = 0; k < NUM_ENC; k++) vals[k] = CNT_W'(k);
    set_cnt();
    exp_seq = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    push_frame(8'h42);
    wait_fs("basic_fs", 2*SD, cyc);
    chk("basic_first_fs_cycle", cyc, SD);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (tx_valid === 1'b1) nvalid++;
      else break;
    end
    chk("basic_frame_len", nvalid, FLEN);
    @(posedge CLK); #1;
    en = 1'b0;
    drain("basic", 100);

    // Backpressure: all channels 1F, random tx_ready.
    for (int k = 0; k < NUM_ENC; k++) vals[k] = 5'h1F;
    set_cnt();
    push_frame(8'h74);
    @(posedge CLK); #1;
    rand_ready = 1'b1; en = 1'b1;
    wait_fs("bp_fs", 2*SD, cyc);
    @(posedge CLK); #1;
    en = 1'b0;
    drain("bp", 500);
    @(posedge CLK); #1;
    rand_ready = 1'b0; tx_ready = 1'b1;
    chk("bp_overrun", overrun, 0);

    // Snapshot atomicity and overrun: stall past the next tick.
    for (int k = 0; k < NUM_ENC; k++) vals[k] = CNT_W'(2*k + 1);
    set_cnt();
    push_frame(8'h90);
    @(posedge CLK); #1;
    tx_ready = 1'b0; en = 1'b1;
    wait_fs("ovr_fs", 2*SD, cyc);
    @(posedge CLK); #1;
    fs0 = fs_count;
    for (int k = 0; k < NUM_ENC; k++) vals[k] = '0;
    set_cnt();
    repeat (SD + 5) @(posedge CLK);
    #1;
    chk("ovr_set", overrun, 1);
    chk("ovr_no_second_fs", fs_count - fs0, 0);
    chk("ovr_valid_held", tx_valid, 1);
    chk("ovr_sync_held", tx_data, 8'hA5);
    en = 1'b0; tx_ready = 1'b1;
    drain("ovr", 100);
    chk("ovr_no_fs_drain", fs_count - fs0, 0);
    push_frame(8'h00);
    @(posedge CLK); #1;
    en = 1'b1;
    wait_fs("rearm_fs", 2*SD, cyc);
    chk("rearm_fs_cycle", cyc, SD);
    @(posedge CLK); #1;
    en = 1'b0;
    drain("rearm", 100);
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of DATA (idx 6), then a clean frame.
    for (int k = 0; k < NUM_ENC; k++) vals[k] = CNT_W'(k + 3);
    set_cnt();
    push_frame(8'h66);
    @(posedge CLK); #1;
    en = 1'b1; tx_ready = 1'b1;
    wait_fs("mid_fs", 2*SD, cyc);
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK);
      if (exp_q.size() == NUM_ENC - 6 + 1) break;
    end
    #1;
    chk("mid_idx6_data", tx_data, 8'(vals[6]));
    chk("mid_idx6_valid", tx_valid, 1);
    RST = 1'b1; tx_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_data", tx_data, 0);
    exp_q.delete();
    exp_seq = 8'd0;
    @(posedge CLK); #1;
    RST = 1'b0; tx_ready = 1'b1;
    push_frame(8'h66);
    wait_fs("post_rst_fs", 2*SD, cyc);
    chk("post_rst_fs_cycle", cyc, SD);
    @(posedge CLK); #1;
    en = 1'b0;
    drain("post_rst", 100);

`ifdef ENC_FRAME_SEQ_EN
    // 257 back-to-back frames: sequence 00..FF then 00.
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_seq = 8'd0;
    for (int k = 0; k < NUM_ENC; k++) vals[k] = CNT_W'(k);
    set_cnt();
    tx_ready = 1'b1; en = 1'b1;
    for (int f = 0; f < 257; f++) begin
      push_frame(8'h42);
      wait_fs("seq_fs", 2*SD, cyc);
      if (cyc == 0) break;
    end
    @(posedge CLK); #1;
    en = 1'b0;
    drain("seq", 100);
    chk("seq_overrun", overrun, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
